fft_frame_gen: RTL and testbench
================================

# fft_frame_gen

Frame generator in front of the FFT window stage. It takes a free-running ADC sample stream with no backpressure and cuts it into frames of exactly `FRAME_LEN` samples, one-shot or continuous. Frames leave on an AXI-Stream master with `tuser` on the first beat and `tlast` on the last beat. A small FIFO absorbs downstream stalls; overruns are flagged and never shorten a frame.

## Interface
Parameters:
- `DW`, 16: sample width.
- `FRAME_LEN`, 1024: samples per frame, ≥2.
- `FIFO_DEPTH`, 16: FIFO entries, power of two, ≥4.
- `DECIM_W`, 8: width of `decim` (only with `FFT_FRAME_GEN_DECIM_EN`).

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sample_in` in DW: ADC sample.
- `sample_valid` in 1: sample strobe; no backpressure to the source.
- `arm` in 1: one-cycle pulse that starts capture.
- `continuous` in 1: back-to-back frames while high; sampled at each frame end.
- `stop` in 1: pulse; in continuous mode, finish the current frame, then stop.
- `decim` in DECIM_W: keep 1 of every decim+1 samples (macro only).
- `tdata_m` out DW, `tvalid_m` out 1, `tuser_m` out 1, `tlast_m` out 1, `tready_m` in 1: output stream.
- `busy` out 1: state ≠ IDLE.
- `overflow` out 1: sticky; a sample was dropped because the FIFO was full.
- `frame_cnt` out 16: frames completed on the output (wraps).

## Operation
- States:
  - IDLE: default. `arm` moves to CAPTURE, clears `overflow`, and sets `idx`=0 and the decimation counter to 0. `arm` is ignored outside IDLE.
  - CAPTURE:
    - Input stage: each accepted sample is registered with `idx`, then written to the FIFO with tags user=(idx==0) and last=(idx==FRAME_LEN-1).
    - Frame end: after the last write, the block restarts at `idx`=0 if `continuous`=1 and no `stop` is latched since arm/previous frame. Otherwise it goes to DRAIN.
    - `stop` during CAPTURE is latched and cleared on leaving CAPTURE.
  - DRAIN: when the FIFO is empty and the input register is empty, go to IDLE.
- FIFO full at write time: the sample is dropped and `overflow` is set. `idx` does not advance, so every frame is still exactly FRAME_LEN beats with exactly one user and one last.
- `frame_cnt` increments on each `tvalid_m && tready_m && tlast_m`.
- Samples arriving in IDLE or DRAIN are discarded.
- `tdata_m` is passed unmodified; there is no arithmetic on data.

## Timing
- Reset values:
  - `tdata_m`=0, `tvalid_m`=`tuser_m`=`tlast_m`=0.
  - `busy`=0, `overflow`=0, `frame_cnt`=0.
  - State IDLE, FIFO empty, `idx`=0.
- Latency: `sample_valid` in cycle N (accepted) → registered at N+1 edge → FIFO write at N+2 edge → `tvalid_m` high in cycle N+2 when the FIFO was empty.
- FIFO is first-word-fall-through. `tvalid_m` = FIFO not empty. Output is held stable while `tvalid_m && !tready_m`.
- Simultaneous FIFO write and read when full: the read frees space first, so the write succeeds and there is no overflow.
- `busy` rises the cycle after `arm` and falls the cycle after DRAIN sees empty.
- `reset_n` asserted mid-frame: immediate return to reset values; the partial frame is lost and no `tlast` is emitted.

## Configuration
- `FFT_FRAME_GEN_DECIM_EN` defined:
  - The `decim` port exists.
  - The counter counts `sample_valid` strobes; a sample is accepted when the counter is 0, and the counter wraps at `decim`.
  - `decim`=0 accepts every sample.
  - `decim` is sampled at `arm`.
- Undefined: no `decim` port and no counter; every `sample_valid` in CAPTURE is accepted.

## Test plan
Bench uses DW=16, FRAME_LEN=8, FIFO_DEPTH=4.
- One-shot: arm, then 20 valid samples 0..19 with `tready_m`=1 → exactly 8 beats 0..7, user on 0, last on 7, `frame_cnt`=1, `busy` low after drain, first `tvalid_m` 2 cycles after the first sample.
- Continuous: `continuous`=1, 24 samples, `stop` pulsed at sample 18 → beats 0..23 as 3 frames, user at 0/8/16, last at 7/15/23, `frame_cnt`=3.
- Backpressure: `tready_m`=0 for 10 cycles during capture of samples 0..7 → `overflow`=1. Still 8 beats with user first and last eighth, values skip the dropped samples; `overflow` clears on the next `arm`.
- Decimation (macro defined, `decim`=2): samples 0..29 → beats 0,3,6,…,21; with the macro undefined, the same stimulus gives 0..7.
- Reset mid-frame: `reset_n` low after 4 outputs → all outputs 0 next cycle, `frame_cnt`=0. A new arm yields a clean frame starting with user.
- `arm` pulsed during CAPTURE → ignored: `idx` continues and the frame is unchanged.

Source files
------------

// File: rtl/fft_frame_gen.sv
// Frame generator: cuts a free-running sample stream into FRAME_LEN-beat AXI-Stream frames through a small FWFT FIFO.
// Optional input decimation is compiled in with FFT_FRAME_GEN_DECIM_EN.
module fft_frame_gen #(
  parameter int DW         = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 16
`ifdef FFT_FRAME_GEN_DECIM_EN
  ,
  parameter int DECIM_W    = 8
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DW-1:0]      sample_in,
  input  logic               sample_valid,
  input  logic               arm,
  input  logic               continuous,
  input  logic               stop,
`ifdef FFT_FRAME_GEN_DECIM_EN
  input  logic [DECIM_W-1:0] decim,
`endif
  output logic [DW-1:0]      tdata_m,
  output logic               tvalid_m,
  output logic               tuser_m,
  output logic               tlast_m,
  input  logic               tready_m,
  output logic               busy,
  output logic               overflow,
  output logic [15:0]        frame_cnt
);

  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0] idx;
  logic          in_vld;
  logic [DW-1:0] in_data;
  logic          stop_lat;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [DW+1:0] mem [FIFO_DEPTH];
  logic [DW+1:0] rd_word;
  logic          fifo_empty, fifo_full, rd_en, wr_req, wr_en;
  logic          frame_end, restart, accept, dec_ok;

  // Output stream: tvalid_m && tready_m is a transfer; data/tags hold while tvalid_m && !tready_m.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en      = !fifo_empty && tready_m;
  assign wr_req     = in_vld && (state == CAPTURE);
  // A same-cycle read frees a slot, so a write into a full FIFO still lands.
  assign wr_en      = wr_req && (!fifo_full || rd_en);
  assign frame_end  = wr_en && (idx == LAST_IDX);
  assign restart    = continuous && !(stop_lat || stop);
  assign accept     = (state == CAPTURE) && sample_valid && dec_ok;

`ifdef FFT_FRAME_GEN_DECIM_EN
  logic [DECIM_W-1:0] dcnt, decim_lat;
  assign dec_ok = (dcnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dcnt      <= '0;
      decim_lat <= '0;
    end else if (state == IDLE && arm) begin
      dcnt      <= '0;
      decim_lat <= decim;
    end else if (state == CAPTURE && sample_valid) begin
      dcnt <= (dcnt == decim_lat) ? '0 : dcnt + 1'b1;
    end
  end
`else
  assign dec_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arm) state_nx = CAPTURE;
      CAPTURE: if (frame_end && !restart) state_nx = DRAIN;
      DRAIN:   if (fifo_empty && !in_vld) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // idx tracks successful FIFO writes, so a dropped sample never consumes a frame slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      in_vld    <= 1'b0;
      in_data   <= '0;
      stop_lat  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      in_vld <= accept;
      if (accept) in_data <= sample_in;
      if (state == IDLE && arm) begin
        idx      <= '0;
        overflow <= 1'b0;
      end else if (wr_en) begin
        idx <= frame_end ? '0 : idx + 1'b1;
      end
      if (wr_req && !wr_en) overflow <= 1'b1;
      stop_lat <= (state == CAPTURE) && (state_nx == CAPTURE) && (stop_lat || stop);
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (rd_word[DW]) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {idx == '0, idx == LAST_IDX, in_data};
  end

  // Storage is never reset, so outputs are gated by tvalid_m to read zero when empty.
  assign rd_word  = mem[rd_ptr[AW-1:0]];
  assign tvalid_m = !fifo_empty;
  assign tdata_m  = tvalid_m ? rd_word[DW-1:0] : '0;
  assign tuser_m  = tvalid_m && rd_word[DW+1];
  assign tlast_m  = tvalid_m && rd_word[DW];
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_fft_frame_gen.sv
// Bench for fft_frame_gen: random stimulus against a queue-based reference of the frame stream.
// Decimation scenarios follow whether FFT_FRAME_GEN_DECIM_EN is defined.
module tb_fft_frame_gen;
  localparam int DW = 16;
  localparam int FRAME_LEN = 8;
  localparam int FIFO_DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] sample_in;
  logic          sample_valid, arm, continuous, stop;
`ifdef FFT_FRAME_GEN_DECIM_EN
  logic [7:0]    decim;
`endif
  logic [DW-1:0] tdata_m;
  logic          tvalid_m, tuser_m, tlast_m, tready_m;
  logic          busy, overflow;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  fft_frame_gen #(.DW(DW), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .arm(arm), .continuous(continuous), .stop(stop),
`ifdef FFT_FRAME_GEN_DECIM_EN
    .decim(decim),
`endif
    .tdata_m(tdata_m), .tvalid_m(tvalid_m), .tuser_m(tuser_m), .tlast_m(tlast_m),
    .tready_m(tready_m), .busy(busy), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: exp_q holds the beats the FIFO should hold, each {user, last, data}.
  logic [DW+1:0] exp_q[$];
  int            m_phase;      // 0 idle, 1 capturing, 2 draining
  int            m_pos;        // position of the next stored beat within its frame
  bit            m_pend;       // a sample accepted last cycle, awaiting storage
  logic [DW-1:0] m_pend_data;
  bit            m_stop, m_ovf;
  int            m_frames, m_beats;
`ifdef FFT_FRAME_GEN_DECIM_EN
  int            m_skip, m_decim;
`endif

  task automatic model_reset();
    exp_q.delete();
    m_phase = 0; m_pos = 0; m_pend = 0; m_pend_data = '0;
    m_stop = 0; m_ovf = 0; m_frames = 0; m_beats = 0;
`ifdef FFT_FRAME_GEN_DECIM_EN
    m_skip = 0; m_decim = 0;
`endif
  endtask

  // Compare this cycle's outputs, advance the reference across the clock edge, return at the negedge.
  task automatic cycle();
    bit hs, was_pend, empty_pre, acc;
    int ph;
    logic [DW-1:0] pd;
    empty_pre = (exp_q.size() == 0);
    check("tvalid", 32'(tvalid_m), 32'(!empty_pre));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("frame_cnt", 32'(frame_cnt), 32'(m_frames % 65536));
    if (!empty_pre) begin
      check("tdata", 32'(tdata_m), 32'(exp_q[0][DW-1:0]));
      check("tuser", 32'(tuser_m), 32'(exp_q[0][DW+1]));
      check("tlast", 32'(tlast_m), 32'(exp_q[0][DW]));
    end
    ph = m_phase; was_pend = m_pend; pd = m_pend_data;
    hs = !empty_pre && tready_m;
    if (hs) begin
      if (exp_q[0][DW]) m_frames++;
      m_beats++;
      void'(exp_q.pop_front());
    end
    if (ph == 1 && was_pend) begin
      if (exp_q.size() < FIFO_DEPTH) begin
        exp_q.push_back({m_pos == 0, m_pos == FRAME_LEN - 1, pd});
        if (m_pos == FRAME_LEN - 1) begin
          m_pos = 0;
          if (!continuous || m_stop || stop) m_phase = 2;
        end else begin
          m_pos++;
        end
      end else begin
        m_ovf = 1;
      end
    end
    if (ph == 1) m_stop = (m_phase == 1) && (m_stop || stop);
`ifdef FFT_FRAME_GEN_DECIM_EN
    acc = (ph == 1) && sample_valid && (m_skip == 0);
    if (ph == 1 && sample_valid) m_skip = (m_skip == m_decim) ? 0 : m_skip + 1;
`else
    acc = (ph == 1) && sample_valid;
`endif
    m_pend = acc;
    m_pend_data = sample_in;
    if (ph == 0 && arm) begin
      m_phase = 1; m_pos = 0; m_ovf = 0;
`ifdef FFT_FRAME_GEN_DECIM_EN
      m_skip = 0; m_decim = int'(decim);
`endif
    end
    if (ph == 2 && empty_pre && !was_pend) m_phase = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cycle();
    arm = 1'b0;
  endtask

  task automatic feed(input int n, input int stop_at, input bit rnd);
    for (int i = 0; i < n; i++) begin
      sample_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      sample_in = DW'($urandom_range(0, 65535));
      stop = (i == stop_at);
      if (rnd) begin
        tready_m = ($urandom_range(0, 3) != 0);
        arm = ($urandom_range(0, 15) == 0);
      end
      cycle();
    end
    sample_valid = 1'b0; stop = 1'b0;
    if (rnd) arm = 1'b0;
  endtask

  // Finish whatever frame is open (supplying samples if needed) and wait for idle.
  task automatic drain();
    int budget;
    budget = 0;
    continuous = 1'b0; stop = 1'b0; arm = 1'b0; tready_m = 1'b1;
    while (m_phase != 0 && budget < 300) begin
      sample_valid = (m_phase == 1);
      sample_in = DW'($urandom_range(0, 65535));
      cycle();
      budget++;
    end
    sample_valid = 1'b0;
    cycle();
    check("busy_after_drain", 32'(busy), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    reset_n = 1'b0; sample_in = '0; sample_valid = 1'b0; arm = 1'b0;
    continuous = 1'b0; stop = 1'b0; tready_m = 1'b1;
`ifdef FFT_FRAME_GEN_DECIM_EN
    decim = 8'd0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(tvalid_m), 32'(0));
    check("rst_tdata", 32'(tdata_m), 32'(0));
    check("rst_tuser", 32'(tuser_m), 32'(0));
    check("rst_tlast", 32'(tlast_m), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // One-shot frame
    pulse_arm();
    feed(20, -1, 0);
    drain();
    check("oneshot_frames", 32'(frame_cnt), 32'(1));

    // Continuous, stop during the third frame
    continuous = 1'b1;
    pulse_arm();
    feed(24, 18, 0);
    drain();
    check("continuous_frames", 32'(frame_cnt), 32'(4));

    // Backpressure causing drops
    tready_m = 1'b0;
    pulse_arm();
    feed(10, -1, 0);
    tready_m = 1'b1;
    feed(10, -1, 0);
    drain();
    check("bp_overflow", 32'(overflow), 32'(1));
    check("bp_frames", 32'(frame_cnt), 32'(5));
    pulse_arm();
    check("overflow_cleared", 32'(overflow), 32'(0));
    drain();
    check("rearm_frames", 32'(frame_cnt), 32'(6));

    // Decimation (plain capture when the feature is compiled out)
`ifdef FFT_FRAME_GEN_DECIM_EN
    decim = 8'd2;
`endif
    pulse_arm();
    feed(30, -1, 0);
    drain();
    check("decim_frames", 32'(frame_cnt), 32'(7));
`ifdef FFT_FRAME_GEN_DECIM_EN
    decim = 8'd0;
`endif

    // arm during capture is ignored
    pulse_arm();
    feed(3, -1, 0);
    arm = 1'b1;
    feed(1, -1, 0);
    arm = 1'b0;
    feed(10, -1, 0);
    drain();
    check("arm_ignored_frames", 32'(frame_cnt), 32'(8));

    // Randomized sessions
    for (int it = 0; it < 8; it++) begin
      continuous = 1'($urandom_range(0, 1));
`ifdef FFT_FRAME_GEN_DECIM_EN
      decim = 8'($urandom_range(0, 3));
`endif
      pulse_arm();
      feed($urandom_range(20, 60), $urandom_range(0, 60), 1);
      drain();
    end

    // Reset in the middle of a frame
    tready_m = 1'b1;
    m_beats = 0;
    pulse_arm();
    b = 0;
    sample_valid = 1'b1;
    while (m_beats < 4 && b < 50) begin
      sample_in = DW'($urandom_range(0, 65535));
      cycle();
      b++;
    end
    sample_valid = 1'b0;
    check("beats_before_reset", 32'(m_beats), 32'(4));
    reset_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(tvalid_m), 32'(0));
    check("mid_rst_tdata", 32'(tdata_m), 32'(0));
    check("mid_rst_tlast", 32'(tlast_m), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'(0));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_arm();
    feed(12, -1, 0);
    drain();
    check("post_reset_frames", 32'(frame_cnt), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
